// File: rtl/t02_keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync/debounce, press detect, key-code FIFO.
// Optional auto-repeat of a held single key is enabled with `define T02_KEYPAD_REPEAT_EN.
module t02_keypad_scanner #(
  parameter int CLK_DIV       = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] read_row,
  output logic [3:0] scan_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overflow
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (CLK_DIV < 4) begin : g_chk_div
    $error("CLK_DIV must be >= 4");
  end
  if (DEBOUNCE < 1) begin : g_chk_deb
    $error("DEBOUNCE must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_FRAMES < 1) begin : g_chk_rep
    $error("REPEAT_FRAMES must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state, state_next;

  logic [3:0]    sync_a, sync_b;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic          dwell_end, frame_end;
  logic [15:0]   snap, frame_new, prev_frame, committed;
  logic [SW-1:0] stable, stable_next;
  logic          commit, press;
  logic [3:0]    press_code;
  logic          push;
  logic [3:0]    push_code;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    scan_col   = 4'b0000;
    case (state)
      IDLE: if (en) state_next = SCAN;
      SCAN: begin
        scan_col = 4'b0001 << col;
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else if (!en) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= read_row;
      sync_b <= sync_a;
    end
  end

  assign dwell_end = (state == SCAN) && (dwell == DW'(CLK_DIV - 1));
  assign frame_end = dwell_end && (col == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      dwell <= '0;
    end else if (!en) begin
      col   <= '0;
      dwell <= '0;
    end else if (state == SCAN) begin
      if (dwell_end) begin
        dwell <= '0;
        col   <= col + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Snapshot bit index is col*4 + row; at frame end this is the whole new frame.
  always_comb begin
    frame_new = snap;
    frame_new[{col, 2'b00} +: 4] = sync_b;
  end

  always_comb begin
    if (frame_new == prev_frame)
      stable_next = (stable == SW'(DEBOUNCE)) ? stable : stable + SW'(1);
    else
      stable_next = SW'(1);
  end

  assign commit = frame_end && (stable_next == SW'(DEBOUNCE)) && (frame_new != committed);
  assign press  = commit && (committed == 16'd0) && (frame_new != 16'd0) &&
                  ((frame_new & (frame_new - 16'd1)) == 16'd0);

  // Snapshot index i = col*4 + row, key code = row*4 + col: swap the two halves.
  always_comb begin
    press_code = 4'h0;
    for (int i = 0; i < 16; i++)
      if (frame_new[i]) press_code = {i[1:0], i[3:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      prev_frame <= '0;
      stable     <= '0;
      committed  <= '0;
    end else if (!en) begin
      snap       <= '0;
      prev_frame <= '0;
      stable     <= '0;
      committed  <= '0;
    end else begin
      if (dwell_end) snap <= frame_new;
      if (frame_end) begin
        prev_frame <= frame_new;
        stable     <= stable_next;
      end
      if (commit) committed <= frame_new;
    end
  end

`ifdef T02_KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_armed, rep_fire;
  logic [3:0]    held_code;

  // Armed only by a genuine press; any later commit (release or extra key) disarms.
  assign rep_fire = frame_end && !commit && rep_armed && (rep_cnt == RW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      held_code <= '0;
    end else if (!en) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      held_code <= '0;
    end else if (commit) begin
      rep_cnt   <= '0;
      rep_armed <= press;
      if (press) held_code <= press_code;
    end else if (frame_end && rep_armed) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
    end
  end

  assign push      = press || rep_fire;
  assign push_code = press ? press_code : held_code;
`else
  assign push      = press;
  assign push_code = press_code;
`endif

  assign key_valid = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = key_ack && key_valid;
  assign do_push   = push && (!full || pop);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'h0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (!en) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_t02_keypad_scanner.sv
// Directed bench for t02_keypad_scanner with CLK_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4 (16-cycle frames).
module tb_t02_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] read_row;
  logic [3:0] scan_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;

  logic [15:0] keys;   // indexed by row*4 + col
  int checks   = 0;
  int failures = 0;

  t02_keypad_scanner #(
    .CLK_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4), .REPEAT_FRAMES(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .read_row(read_row), .scan_col(scan_col),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Passive keypad matrix: a closed key connects its column strobe to its row.
  always_comb begin
    read_row = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && scan_col[c]) read_row[r] = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press a key at a frame start, hold 3 frames, release 3 frames; ends frame-aligned.
  task automatic tap(input int code);
    keys[code] = 1'b1;
    step(48);
    keys = '0;
    step(48);
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    chk({tag, "_valid"}, 16'(key_valid), 16'd1);
    chk({tag, "_code"}, 16'(key_code), 16'(exp));
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; keys = '0; key_ack = 1'b0;
    step(2);
    chk("rst_scan_col", 16'(scan_col), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_overflow", 16'(overflow), 16'h0);
    chk("rst_code", 16'(key_code), 16'h0);

    // Scan order with no keys; one frame after this block we sit at a frame start.
    rst = 1'b0; en = 1'b1;
    step(1);  chk("scan_c0_first", 16'(scan_col), 16'b0001);
    step(3);  chk("scan_c0_last", 16'(scan_col), 16'b0001);
    step(1);  chk("scan_c1", 16'(scan_col), 16'b0010);
    step(4);  chk("scan_c2", 16'(scan_col), 16'b0100);
    step(4);  chk("scan_c3", 16'(scan_col), 16'b1000);
    step(4);  chk("scan_wrap", 16'(scan_col), 16'b0001);
    chk("idle_valid", 16'(key_valid), 16'h0);

    // Single key row1/col2: commit on the second frame end, 32 cycles after press.
    keys[6] = 1'b1;
    step(31); chk("k6_before_commit", 16'(key_valid), 16'h0);
    step(1);  chk("k6_valid", 16'(key_valid), 16'h1);
    chk("k6_code", 16'(key_code), 16'h6);
    step(32); chk("k6_held_code", 16'(key_code), 16'h6);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("k6_single_push", 16'(key_valid), 16'h0);
    keys = '0;
    step(47);

    // Row0/col0 bouncing every 5 cycles, then stable.
    for (int k = 0; k < 10; k++) begin
      keys[0] = (k % 2 == 0);
      step(5);
    end
    chk("bounce_no_push", 16'(key_valid), 16'h0);
    keys[0] = 1'b1;
    step(32); chk("bounce_settling", 16'(key_valid), 16'h0);
    step(16); chk("bounce_valid", 16'(key_valid), 16'h1);
    chk("bounce_code", 16'(key_code), 16'h0);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("bounce_single", 16'(key_valid), 16'h0);
    keys = '0;
    step(45);

    // Two keys, then one of them, then release and a clean press.
    keys[9] = 1'b1; keys[11] = 1'b1;
    step(48); chk("multi_no_push", 16'(key_valid), 16'h0);
    keys[11] = 1'b0;
    step(48); chk("two_to_one_no_push", 16'(key_valid), 16'h0);
    keys = '0;
    step(48); chk("release_no_push", 16'(key_valid), 16'h0);
    keys[9] = 1'b1;
    step(48); chk("k9_valid", 16'(key_valid), 16'h1);
    chk("k9_code", 16'(key_code), 16'h9);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("k9_popped", 16'(key_valid), 16'h0);
    keys = '0;
    step(47);

    // Fill the FIFO, then overflow on the fifth press.
    tap(3); tap(5); tap(10); tap(12);
    chk("full_overflow_clear", 16'(overflow), 16'h0);
    chk("full_head", 16'(key_code), 16'h3);
    tap(15);
    chk("overflow_set", 16'(overflow), 16'h1);

    // Sixth press lands on the same edge as a pop of a full FIFO.
    keys[7] = 1'b1;
    step(31);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("pushpop_valid", 16'(key_valid), 16'h1);
    chk("pushpop_head", 16'(key_code), 16'h5);
    chk("overflow_sticky", 16'(overflow), 16'h1);
    step(16);
    keys = '0;
    step(48);
    pop_chk("q0", 4'h5);
    pop_chk("q1", 4'hA);
    pop_chk("q2", 4'hC);
    pop_chk("q3", 4'h7);
    chk("q_empty", 16'(key_valid), 16'h0);
    step(12);

    // Async reset mid-dwell with two codes queued.
    tap(1); tap(2);
    chk("pre_rst_valid", 16'(key_valid), 16'h1);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_scan_col", 16'(scan_col), 16'h0);
    chk("async_rst_valid", 16'(key_valid), 16'h0);
    chk("async_rst_overflow", 16'(overflow), 16'h0);
    chk("async_rst_code", 16'(key_code), 16'h0);
    step(1);
    rst = 1'b0;
    step(1);

    // Hold 4'h6 for 12 frames after its push.
    keys[6] = 1'b1;
    step(232);
    chk("hold_overflow", 16'(overflow), 16'h0);
`ifdef T02_KEYPAD_REPEAT_EN
    pop_chk("rep0", 4'h6);
    pop_chk("rep1", 4'h6);
    pop_chk("rep2", 4'h6);
    pop_chk("rep3", 4'h6);
`else
    pop_chk("hold_once", 4'h6);
`endif
    chk("hold_drained", 16'(key_valid), 16'h0);
    keys = '0;
    step(48);

    // en low flushes the FIFO and stops the strobes.
    keys[13] = 1'b1;
    for (int i = 0; i < 64 && !key_valid; i++) step(1);
    chk("en_pre_valid", 16'(key_valid), 16'h1);
    chk("en_pre_code", 16'(key_code), 16'hD);
    en = 1'b0;
    step(1);
    chk("en_low_valid", 16'(key_valid), 16'h0);
    chk("en_low_scan_col", 16'(scan_col), 16'h0);
    keys = '0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t02_keypad_scanner.md
Name: t02_keypad_scanner

Overview:
- Scans the 4x4 matrix keypad wired to the chip GPIOs.
- Drives the column strobes, synchronises and debounces the row returns, and detects single-key press events.
- Queues press events as 4-bit key codes in a small FIFO.
- Directly upstream of the t02_top CPU's keypad input. The CPU pops codes with a valid/ack handshake instead of sampling raw row lines.

Parameters:
- CLK_DIV, 1000: clk cycles each column is driven (dwell); must be >= 4.
- DEBOUNCE, 4: consecutive identical full-matrix frames required to commit a new keypad state; must be >= 1.
- FIFO_DEPTH, 4: key-code FIFO entries; power of two, >= 2.
- REPEAT_FRAMES, 32: auto-repeat interval in frames. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  block enable; low = idle and flushed
- read_row  in  4  keypad row returns, active-high, asynchronous to clk
- scan_col  out  4  column strobes, one-hot active-high
- key_code  out  4  FIFO head: row_index*4 + col_index
- key_valid  out  1  FIFO non-empty
- key_ack  in  1  pop FIFO head this cycle; ignored when key_valid = 0
- overflow  out  1  sticky flag: a press was dropped because the FIFO was full

Behaviour:
- Reset (rst high, asynchronous) clears everything:
  - scan_col = 0, key_code = 0, key_valid = 0, overflow = 0.
  - Column index, dwell counter, synchroniser, frame snapshot, stable counter, committed state and FIFO pointers all cleared.
- en low, sampled synchronously, has the same effect as reset on the next edge. The FIFO is flushed. Scanning restarts at column 0 when en returns high.
- Synchroniser: read_row passes through a 2-flop synchroniser before any use.
- Scan sequence:
  - Column index c cycles 0,1,2,3,0,... and scan_col = 1 << c.
  - Dwell counter counts 0..CLK_DIV-1 per column.
  - On dwell count CLK_DIV-1, the synchronised rows are latched into snapshot bits [c*4 +: 4]; bit r corresponds to row r.
  - Frame end is dwell count CLK_DIV-1 with c = 3. One frame = 4*CLK_DIV cycles.
- Debounce, evaluated at each frame end:
  - If the new snapshot equals the previous frame's snapshot, the stable counter increments, saturating at DEBOUNCE. Otherwise it resets to 1.
  - When the counter reaches DEBOUNCE and the snapshot differs from the committed state, the committed state is updated to the snapshot.
- Press event:
  - Fires when a commit moves from a state with zero keys set to a state with exactly one key set.
  - Pushed code = row*4 + col of that key.
  - Multi-key states never push.
  - Going from one key to two keys and back to one does not push; all keys must be released first.
- Latency: the push occurs on the frame-end edge that commits. key_valid is high from the following cycle.
- FIFO:
  - Synchronous; key_code is the head, shown combinationally from registered storage.
  - A pop happens when key_ack = 1 and key_valid = 1.
  - Push when full with no pop: the code is dropped and overflow is set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: impossible, since the pop requires key_valid.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a (log2 FIFO_DEPTH)+1-bit count.
- overflow stays set until rst or en low.
- State machine: IDLE (en low) -> SCAN (en high); SCAN -> IDLE when en goes low. Column and dwell logic run only in SCAN.

Optional Feature:
- Macro: T02_KEYPAD_REPEAT_EN.
- Defined:
  - While the committed state holds exactly one key, a repeat counter counts frames from the press push.
  - The same code is pushed every REPEAT_FRAMES frames, with overflow rules as for a normal push.
  - The counter clears on any commit or when en is low.
- Undefined: no repeat logic is synthesised. REPEAT_FRAMES is unused; one push per press.

Test Plan (CLK_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4; one frame = 16 cycles):
- Reset, then en=1, no key pressed -> scan_col steps 0001, 0010, 0100, 1000, changing every 4 cycles; key_valid stays 0.
- Hold row1/col2 (read_row=0010 while scan_col=0100) for 4 frames -> exactly one push, key_code=4'h6, key_valid high within 3 frames. key_ack pulse -> key_valid=0.
- Row0/col0 bouncing, changing every 5 cycles for 3 frames, then stable for 3 frames -> a single push of 4'h0, and only after the stable period.
- Press col1 and col3 of row2 together -> no push. Release col3, keep col1 -> still no push. Release all, press row2/col1 -> push 4'h9.
- 5 distinct presses with no acks -> 4 queued in order, overflow=1 after the 5th. A 6th press arriving in the same cycle as a key_ack with the FIFO full -> accepted, no extra drop.
- Assert rst mid-dwell with 2 codes queued -> scan_col=0, key_valid=0, overflow=0 immediately. With T02_KEYPAD_REPEAT_EN and REPEAT_FRAMES=4, holding 4'h6 for 12 frames after the push -> 3 additional pushes of 4'h6.
